// File: rtl/frame_ram_if.sv
// frame_ram_if
//   Bundles the signals that the frame RAM arbiter shares with the pixel
//   loader, the readout engine and the single-port frame RAM.
//
//   Parameters
//     PIXEL_COUNT  pixels per frame (sets ADDR_W = $clog2(PIXEL_COUNT))
//     DATA_W       pixel width
//
//   Modports
//     slave   arbiter view: takes loader writes, read requests and RAM read
//             data; drives the read handshake, RAM controls and frame status
//     master  environment view (loader + readout engine + RAM)
interface frame_ram_if #(
  parameter int PIXEL_COUNT = 172800,
  parameter int DATA_W      = 24
);
  localparam int ADDR_W = $clog2(PIXEL_COUNT);

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              frame_done;
  logic              frame_ready;
  logic              wr_overflow;

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_req, rd_addr,
    output rd_ack, rd_valid, rd_data,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output frame_done, frame_ready, wr_overflow
  );

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_req, rd_addr,
    input  rd_ack, rd_valid, rd_data,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  frame_done, frame_ready, wr_overflow
  );
endinterface

// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter
//   Shares the single-port pixel frame RAM between the UART pixel loader
//   (writes) and the pixel readout engine (reads). Each single-cycle loader
//   write is captured in a one-entry holding buffer, one RAM access is granted
//   per cycle, read data returns with a fixed latency, and committed pixels
//   are counted to flag complete frames.
//
//   Parameters
//     PIXEL_COUNT  pixels per frame, ADDR_W = $clog2(PIXEL_COUNT)
//     DATA_W       pixel width (RGB 8:8:8 by default)
//     RAM_LATENCY  RAM read latency in cycles (1 or 2)
//
//   Ports
//     clk    clock
//     reset  synchronous, active-high
//     bus    frame_ram_if.slave:
//              wr_valid/wr_addr/wr_data   loader write pulse
//              rd_req/rd_addr -> rd_ack   read request held until ack
//              rd_valid/rd_data           read return, RAM_LATENCY+2 after ack
//              ram_we/ram_addr/ram_wdata  registered RAM controls
//              ram_rdata                  RAM read data
//              frame_done                 pulse with the last pixel of a frame
//              frame_ready                level, set after the first frame
//              wr_overflow                sticky, a loader write was dropped
//
//   Build option
//     ARB_ROUND_ROBIN_EN  when defined, write/read contention alternates
//                         (write wins the first one after reset); otherwise
//                         writes always win contention.
module frame_ram_arbiter #(
  parameter int PIXEL_COUNT = 172800,
  parameter int DATA_W      = 24,
  parameter int RAM_LATENCY = 1
) (
  input  logic     clk,
  input  logic     reset,
  frame_ram_if.slave bus
);

  localparam int ADDR_W = $clog2(PIXEL_COUNT);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXEL_COUNT - 1);

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_WR   = 2'd1,
    G_RD   = 2'd2
  } gstate_t;

  gstate_t state, state_d;

  logic              wbuf_full;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [DATA_W-1:0] wbuf_data;

  logic              contention;
  logic              wr_wins;
  logic              wr_grant;
  logic              rd_grant;

  logic [ADDR_W-1:0] frame_cnt;
  logic              frame_done_q;
  logic              frame_ready_q;
  logic              wr_overflow_q;

  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;

  // Read tags: bit i is set i+1 cycles after the grant. The last tap lines
  // up with valid data on ram_rdata for the configured RAM latency.
  logic [RAM_LATENCY:0] vld_p;
  logic                 rd_valid_q;
  logic [DATA_W-1:0]    rd_data_q;

  assign contention = wbuf_full & bus.rd_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Flag remembers who won the last contention; it starts at "read" so the
  // write side wins the first contention after reset. Uncontended grants do
  // not touch it, so contentions strictly alternate.
  logic last_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_rd <= 1'b1;
    end else if (contention) begin
      last_rd <= rd_grant;
    end
  end

  assign wr_wins = last_rd;
`else
  assign wr_wins = 1'b1;
`endif

  // Grant decision for this cycle; the decided state becomes the registered
  // RAM command next cycle.
  always_comb begin
    state_d = G_IDLE;
    if (!reset) begin
      if (wbuf_full && (!bus.rd_req || wr_wins)) begin
        state_d = G_WR;
      end else if (bus.rd_req) begin
        state_d = G_RD;
      end
    end
  end

  assign wr_grant   = (state_d == G_WR);
  assign rd_grant   = (state_d == G_RD);
  assign bus.rd_ack = rd_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= G_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Holding buffer. A write arriving while the buffer is full is only lost
  // when the buffered entry is not leaving in the same cycle; a grant and a
  // refill in one cycle simply replaces the entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbuf_full     <= 1'b0;
      wr_overflow_q <= 1'b0;
    end else begin
      if (bus.wr_valid) begin
        if (wbuf_full && !wr_grant) begin
          wr_overflow_q <= 1'b1;
        end else begin
          wbuf_full <= 1'b1;
        end
      end else if (wr_grant) begin
        wbuf_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_valid && (!wbuf_full || wr_grant)) begin
      wbuf_addr <= bus.wr_addr;
      wbuf_data <= bus.wr_data;
    end
  end

  // RAM command register: address and write data follow the granted side;
  // in an idle cycle the address is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      case (state_d)
        G_WR: begin
          ram_addr_q  <= wbuf_addr;
          ram_wdata_q <= wbuf_data;
        end
        G_RD: begin
          ram_addr_q <= bus.rd_addr;
        end
        default: begin
          ram_addr_q <= ram_addr_q;
        end
      endcase
    end
  end

  assign bus.ram_we    = (state == G_WR);
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

  // Frame counter advances at the grant so frame_done lands in the same cycle
  // as the ram_we that commits the last pixel. It counts commits only; the
  // write address is irrelevant here.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt     <= '0;
      frame_done_q  <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (wr_grant) begin
        if (frame_cnt == LAST_PIX) begin
          frame_cnt     <= '0;
          frame_done_q  <= 1'b1;
          frame_ready_q <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.frame_done  = frame_done_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.wr_overflow = wr_overflow_q;

  // ---- stage p0..pN: read tag delay line ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p <= {vld_p[RAM_LATENCY-1:0], rd_grant};
    end
  end

  // ---- return stage: capture RAM data under the last tag ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= vld_p[RAM_LATENCY];
      if (vld_p[RAM_LATENCY]) begin
        rd_data_q <= bus.ram_rdata;
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
module tb_frame_ram_arbiter;

  localparam int PC  = 16;
  localparam int DW  = 24;
  localparam int LAT = 1;
  localparam int AW  = $clog2(PC);
  localparam logic [DW-1:0] KEY = 24'h123456;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_ram_if #(.PIXEL_COUNT(PC), .DATA_W(DW)) bus ();

  frame_ram_arbiter #(.PIXEL_COUNT(PC), .DATA_W(DW), .RAM_LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // RAM stand-in: one-cycle read latency, data is a fixed function of address
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) ram_q <= DW'(bus.ram_addr) ^ KEY;
  assign bus.ram_rdata = ram_q;

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            fd;
    int            due;
  } wexp_t;
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];

  int            cyc = 0;
  bit            m_wfull = 0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;
  bit            m_last_rd = 1;
  int            m_cnt = 0;
  bit            m_ovf = 0;
  bit            m_fready = 0;
  bit            m_acked = 0;

  // Does the buffered write take the RAM this cycle?
  function automatic bit write_wins(bit wfull, bit req, bit last_rd);
    if (!wfull) return 1'b0;
    if (!req) return 1'b1;
    return RR ? last_rd : 1'b1;
  endfunction

  always @(posedge clk) begin
    bit gw, gr, fd;
    if (reset) begin
      m_wfull = 0; m_last_rd = 1; m_cnt = 0; m_ovf = 0; m_fready = 0; m_acked = 0;
      wq.delete();
      rq.delete();
    end else begin
      gw = write_wins(m_wfull, bus.rd_req, m_last_rd);
      gr = bus.rd_req && !gw;
      if (m_wfull && bus.rd_req) m_last_rd = gr;
      if (gw) begin
        fd = (m_cnt == PC - 1);
        m_cnt = fd ? 0 : m_cnt + 1;
        if (fd) m_fready = 1;
        wq.push_back('{m_waddr, m_wdata, fd, cyc + 1});
      end
      if (gr) rq.push_back('{DW'(bus.rd_addr) ^ KEY, cyc + 2 + LAT});
      if (bus.wr_valid) begin
        if (m_wfull && !gw) m_ovf = 1;
        else begin
          m_wfull = 1; m_waddr = bus.wr_addr; m_wdata = bus.wr_data;
        end
      end else if (gw) begin
        m_wfull = 0;
      end
      m_acked = gr;
    end
    cyc++;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    wexp_t we;
    rexp_t re;
    bit exp_ack;
    exp_ack = !reset && bus.rd_req && !write_wins(m_wfull, bus.rd_req, m_last_rd);
    chk("rd_ack", 64'(bus.rd_ack), 64'(exp_ack));
    chk("wr_overflow", 64'(bus.wr_overflow), 64'(m_ovf));
    chk("frame_ready", 64'(bus.frame_ready), 64'(m_fready));
    if (bus.ram_we) begin
      if (wq.size() == 0) chk("ram_we_spurious", 64'(1), 64'(0));
      else begin
        we = wq.pop_front();
        chk("ram_we_cycle", 64'(cyc), 64'(we.due));
        chk("ram_addr", 64'(bus.ram_addr), 64'(we.addr));
        chk("ram_wdata", 64'(bus.ram_wdata), 64'(we.data));
        chk("frame_done", 64'(bus.frame_done), 64'(we.fd));
      end
    end else begin
      chk("frame_done_idle", 64'(bus.frame_done), 64'(0));
      if (wq.size() != 0 && wq[0].due <= cyc) begin
        chk("ram_we_missing", 64'(0), 64'(1));
        void'(wq.pop_front());
      end
    end
    if (bus.rd_valid) begin
      if (rq.size() == 0) chk("rd_valid_spurious", 64'(1), 64'(0));
      else begin
        re = rq.pop_front();
        chk("rd_valid_cycle", 64'(cyc), 64'(re.due));
        chk("rd_data", 64'(bus.rd_data), 64'(re.data));
      end
    end else if (rq.size() != 0 && rq[0].due <= cyc) begin
      chk("rd_valid_missing", 64'(0), 64'(1));
      void'(rq.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_ram_we", 64'(bus.ram_we), 64'(0));
    chk("rst_ram_addr", 64'(bus.ram_addr), 64'(0));
    chk("rst_ram_wdata", 64'(bus.ram_wdata), 64'(0));
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
    chk("rst_rd_data", 64'(bus.rd_data), 64'(0));
    chk("rst_frame_done", 64'(bus.frame_done), 64'(0));
    chk("rst_frame_ready", 64'(bus.frame_ready), 64'(0));
    chk("rst_wr_overflow", 64'(bus.wr_overflow), 64'(0));
  endtask

  // Hold rd_req until the model reports the grant; clears wr_valid each cycle.
  task automatic wait_ack();
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.wr_valid = 1'b0;
      if (m_acked) begin
        bus.rd_req = 1'b0;
        return;
      end
    end
    chk("rd_ack_timeout", 64'(0), 64'(1));
    bus.rd_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    idle(3);
    @(negedge clk);
    check_reset_vals();
    tick();
    reset = 1'b0;
    idle(2);

    // single write: ram_we two cycles after wr_valid
    bus.wr_valid = 1'b1; bus.wr_addr = AW'(5); bus.wr_data = 24'hA1B2C3;
    tick();
    bus.wr_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("sw_we", 64'(bus.ram_we), 64'(1));
    chk("sw_addr", 64'(bus.ram_addr), 64'(5));
    chk("sw_data", 64'(bus.ram_wdata), 64'hA1B2C3);
    idle(3);

    // single read: ack same cycle, data three cycles later
    bus.rd_req = 1'b1; bus.rd_addr = AW'(10);
    @(negedge clk);
    chk("sr_ack", 64'(bus.rd_ack), 64'(1));
    tick();
    bus.rd_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("sr_valid", 64'(bus.rd_valid), 64'(1));
    chk("sr_data", 64'(bus.rd_data), 64'h12345C);
    idle(3);

    // contention 1: write always wins the first one
    bus.wr_valid = 1'b1; bus.wr_addr = AW'(7); bus.wr_data = 24'h0F0F0F;
    tick();
    bus.wr_valid = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = AW'(3);
    @(negedge clk);
    chk("cont1_ack", 64'(bus.rd_ack), 64'(0));
    wait_ack();
    idle(3);

    // contention 2: read wins only with round robin
    bus.wr_valid = 1'b1; bus.wr_addr = AW'(8); bus.wr_data = 24'h00FF00;
    tick();
    bus.wr_valid = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = AW'(4);
    @(negedge clk);
    chk("cont2_ack", 64'(bus.rd_ack), 64'(RR));
    wait_ack();
    idle(4);

    // back-to-back writes against a read: dropped only when the read wins
    bus.wr_valid = 1'b1; bus.wr_addr = AW'(1); bus.wr_data = 24'h111111;
    tick();
    bus.wr_addr = AW'(2); bus.wr_data = 24'h222222;
    bus.rd_req = 1'b1; bus.rd_addr = AW'(6);
    tick();
    bus.wr_addr = AW'(3); bus.wr_data = 24'h333333;
    wait_ack();
    idle(4);
    @(negedge clk);
    chk("ovf_flag", 64'(bus.wr_overflow), 64'(RR));
    idle(4);
    @(negedge clk);
    chk("ovf_sticky", 64'(bus.wr_overflow), 64'(RR));
    tick();

    // reset one cycle after a read grant: the read never returns
    bus.rd_req = 1'b1; bus.rd_addr = AW'(10);
    @(negedge clk);
    chk("rr_ack", 64'(bus.rd_ack), 64'(1));
    tick();
    bus.rd_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    tick();
    @(negedge clk);
    chk("rr_no_valid", 64'(bus.rd_valid), 64'(0));
    idle(3);

    // full frame of paced writes, then one more
    for (int i = 0; i < PC; i++) begin
      bus.wr_valid = 1'b1; bus.wr_addr = AW'(i); bus.wr_data = DW'($urandom);
      tick();
      bus.wr_valid = 1'b0;
      idle(7);
    end
    @(negedge clk);
    chk("frame_ready_set", 64'(bus.frame_ready), 64'(1));
    tick();
    bus.wr_valid = 1'b1; bus.wr_addr = '0; bus.wr_data = DW'($urandom);
    tick();
    bus.wr_valid = 1'b0;
    idle(6);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 999) == 0);
      bus.wr_valid = ($urandom_range(0, 3) == 0);
      bus.wr_addr = AW'($urandom);
      bus.wr_data = DW'($urandom);
      if (bus.rd_req && m_acked) bus.rd_req = 1'b0;
      if (!bus.rd_req && $urandom_range(0, 1) == 1) begin
        bus.rd_req = 1'b1;
        bus.rd_addr = AW'($urandom);
      end
      tick();
    end
    reset = 1'b0;
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 10 && bus.rd_req; i++) begin
      tick();
      if (m_acked) bus.rd_req = 1'b0;
    end
    bus.rd_req = 1'b0;
    idle(10);
    @(negedge clk);
    chk("wq_drained", 64'(wq.size()), 64'(0));
    chk("rq_drained", 64'(rq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_ram_arbiter.md
# frame_ram_arbiter

Shares the single-port pixel frame RAM between the UART pixel loader (write requester) and the pixel readout/processing engine (read requester). Captures each single-cycle loader write into a one-entry holding buffer so no pixel is ever silently lost. Grants one RAM access per cycle and returns read data with a fixed latency. Counts committed pixels to flag complete frames.

## Interface
Parameters:
- PIXEL_COUNT, 172800, pixels per frame; localparam ADDR_W = $clog2(PIXEL_COUNT)
- DATA_W, 24, pixel width (RGB 8:8:8)
- RAM_LATENCY, 1, RAM read latency in cycles (1 or 2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_valid  in  1  single-cycle write pulse from loader
- wr_addr  in  ADDR_W  write address, sampled with wr_valid
- wr_data  in  DATA_W  write pixel, sampled with wr_valid
- rd_req  in  1  read request, held with rd_addr until rd_ack
- rd_addr  in  ADDR_W  read address
- rd_ack  out  1  read granted this cycle (combinational, 1-cycle pulse)
- rd_valid  out  1  rd_data valid (1-cycle pulse)
- rd_data  out  DATA_W  read pixel
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_rdata  in  DATA_W  RAM read data
- frame_done  out  1  pulse when last pixel of a frame is committed
- frame_ready  out  1  level, set after first complete frame
- wr_overflow  out  1  sticky, a write was dropped

## Operation
- Write buffer: wr_valid loads wbuf (addr, data), sets wbuf_full. Cleared when the write is granted. If wr_valid arrives while wbuf_full and the write is not granted that same cycle: new write dropped, wr_overflow set (sticky until reset). Granted-and-refilled in the same cycle is legal, not overflow.
- Grant FSM (registered, one grant per cycle): states G_IDLE, G_WR, G_RD. Each cycle: wbuf_full only -> G_WR; rd_req only -> G_RD; neither -> G_IDLE; both -> per priority policy (see Configuration).
- G_WR: ram_we=1, ram_addr/ram_wdata from wbuf. G_RD: ram_we=0, ram_addr=rd_addr, rd_ack=1 in the deciding cycle. G_IDLE: ram_we=0, ram_addr holds.
- Read return: delay line of RAM_LATENCY+1 stages tags granted reads; rd_data registered from ram_rdata.
- Frame counter (ADDR_W bits) increments on every cycle ram_we=1; at PIXEL_COUNT-1 it wraps to 0, frame_done pulses that cycle, frame_ready set. Counter is independent of write address; address wrap is the loader's job.
- Reset values: rd_ack 0, rd_valid 0, rd_data 0, ram_we 0, ram_addr 0, ram_wdata 0, frame_done 0, frame_ready 0, wr_overflow 0; wbuf empty, counter 0, state G_IDLE.
- Reset mid-operation: buffered write and in-flight reads discarded; no rd_valid after reset.

## Timing
- wr_valid in cycle N, no contention -> ram_we=1 in N+2 with captured addr/data.
- rd_req with rd_ack in cycle M -> ram_addr valid M+1 -> rd_valid/rd_data in M+2+RAM_LATENCY (M+3 for latency 1).
- Back-to-back reads: one accepted per cycle; rd_valid stream matches ack order.
- Loader delivers at most one pixel every 8 cycles; worst-case write wait is one cycle, so overflow indicates a protocol error.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on contention, alternate by last-grant flag (write, read, write...); reset last-grant = read so write wins first contention. A write can wait one cycle; overflow possible only if wr_valid repeats next cycle.
- Undefined: strict write priority; on contention write always granted, rd_ack withheld; wr_overflow never set.

## Test plan
- Single write: wr_valid at N, wr_addr=5, wr_data=24'hA1B2C3 -> N+2 ram_we=1, ram_addr=5, ram_wdata=24'hA1B2C3; wbuf empty after.
- Single read: RAM model returns addr^24'h123456; rd_req with rd_addr=10 -> rd_ack same cycle, rd_valid 3 cycles later, rd_data=24'h12345C.
- Contention: wbuf_full and rd_req same cycle -> strict: write first, rd_ack next cycle; with ARB_ROUND_ROBIN_EN, second contention grants read first.
- Frame wrap (PIXEL_COUNT=4): 4 writes -> frame_done pulses with 4th ram_we, frame_ready=1; 5th write counts from 0, no pulse.
- Overflow (ARB_ROUND_ROBIN_EN, read won contention): wr_valid on consecutive cycles -> second write dropped, wr_overflow=1 and stays 1.
- Reset mid-read: reset 1 cycle after rd_ack -> rd_valid stays 0, all outputs at reset values.
